// File: rtl/usb_tx.sv
// USB 1.1 low-speed transmitter: SYNC, LSB-first bytes with bit stuffing and
// NRZI encoding, then EOP, driven as J/K/SE0 line states with an output enable.
package usb_types_pkg;
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10
  } d_port_t;
endpackage

module usb_tx
  import usb_types_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output d_port_t    d,
  output logic       oe,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    ones_q, ones_d;
  logic          ready_q, ready_d;
  d_port_t       line_q, line_d;

  logic    bitWrap;
  logic    doEmit;
  logic    emitBit;
  d_port_t toggled;

  assign bitWrap = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign toggled = (line_q == J) ? K : J;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      ones_q   <= '0;
      ready_q  <= 1'b0;
      line_q   <= J;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      ones_q   <= ones_d;
      ready_q  <= ready_d;
      line_q   <= line_d;
    end
  end

  // SYNC is shifted out of the same register as data (0x80, LSB first), so both
  // states share the bit/stuff/byte-boundary logic; shift_q[0] is the bit on the line.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    ones_d   = ones_q;
    ready_d  = 1'b0;
    line_d   = line_q;
    doEmit   = 1'b0;
    emitBit  = 1'b0;
    if (state_q != IDLE && !bitWrap) begin
      timer_d = timer_q + TW'(1);
    end
    unique case (state_q)
      IDLE: begin
        line_d = J;
        if (tx_valid) begin
          state_d  = SYNC;
          line_d   = K;
          ones_d   = '0;
          shift_d  = 8'h80;
          bitCnt_d = '0;
        end
      end
      SYNC, DATA: begin
        if (bitWrap) begin
          if (ones_q == 3'd6) begin
            line_d = toggled;
            ones_d = '0;
          end else if (bitCnt_q == 3'd7) begin
            bitCnt_d = '0;
            if (tx_valid) begin
              state_d = DATA;
              shift_d = tx_data;
              ready_d = 1'b1;
              doEmit  = 1'b1;
              emitBit = tx_data[0];
            end else begin
              state_d = EOP_SE0;
            end
          end else begin
            shift_d  = shift_q >> 1;
            bitCnt_d = bitCnt_q + 3'd1;
            doEmit   = 1'b1;
            emitBit  = shift_q[1];
          end
        end
      end
      EOP_SE0: begin
        if (bitWrap) begin
          if (bitCnt_q == 3'd1) begin
            state_d = EOP_J;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (bitWrap) begin
          state_d = IDLE;
          line_d  = J;
        end
      end
      default: state_d = IDLE;
    endcase
    // NRZI: a 0 toggles the line and breaks the run of ones, a 1 holds it.
    if (doEmit) begin
      if (emitBit) begin
        ones_d = ones_q + 3'd1;
      end else begin
        ones_d = '0;
        line_d = toggled;
      end
    end
  end

  always_comb begin
    tx_ready = ready_q;
    oe       = (state_q != IDLE);
    busy     = (state_q != IDLE);
    unique case (state_q)
      SYNC, DATA: d = line_q;
      EOP_SE0:    d = SE0;
      default:    d = J;
    endcase
  end

endmodule
